// File: rtl/golomb_pkg.sv
// Shared definitions for the Golomb ruler search: recorder FSM states, the
// pair-count helper and a width-limited saturating increment.
package golomb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of mark pairs (i<j) on a ruler whose last mark has index n.
    function automatic int unsigned num_pairs(input int unsigned n);
        return ((n + 1) * n) / 2;
    endfunction

    // Increment v, sticking at the all-ones value of a w-bit counter (w <= 16).
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input int unsigned w);
        logic [15:0] top_val;
        top_val = 16'((17'(1) << w) - 17'd1);
        return (v >= top_val) ? top_val : v + 16'd1;
    endfunction

endpackage

// File: rtl/golomb_pair_checker.sv
// Walks every mark pair (i<j) of a latched ruler, one pair per cycle, and
// flags a repeated or non-positive distance using a seen-vector.
module golomb_pair_checker
    import golomb_pkg::*;
#(
    parameter int unsigned NUMPOSITIONS = 5,
    parameter int unsigned POSW         = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             i_start,
    input  logic                             i_abort,
    input  logic [(NUMPOSITIONS+1)*POSW-1:0] i_marks,
    output logic                             o_busy,
    output logic                             o_last,
    output logic                             o_ok
);

    localparam int unsigned NPAIRS = num_pairs(NUMPOSITIONS);
    localparam int unsigned IW     = $clog2(NUMPOSITIONS + 1);
    localparam int unsigned CW     = $clog2(NPAIRS + 1);

    logic [IW-1:0]          r_i;
    logic [IW-1:0]          r_j;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_bad;
    logic [(1<<POSW)-1:0]   r_seen;
    logic [POSW-1:0]        w_mi;
    logic [POSW-1:0]        w_mj;
    logic [POSW-1:0]        w_dist;
    logic                   w_cur_bad;

    always_comb begin
        w_mi = '0;
        w_mj = '0;
        for (int unsigned k = 0; k <= NUMPOSITIONS; k++) begin
            if (r_i == IW'(k)) w_mi = i_marks[(NUMPOSITIONS-k)*POSW +: POSW];
            if (r_j == IW'(k)) w_mj = i_marks[(NUMPOSITIONS-k)*POSW +: POSW];
        end
    end

    assign w_dist    = w_mj - w_mi;
    assign w_cur_bad = (w_mj <= w_mi) || r_seen[w_dist];

    assign o_busy = r_busy;
    assign o_last = (r_cnt == CW'(NPAIRS - 1));
    // o_ok already folds in the pair being visited this cycle.
    assign o_ok   = !r_bad && !w_cur_bad;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_i    <= '0;
            r_j    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_bad  <= 1'b0;
            r_seen <= '0;
        end else if (i_start) begin
            r_i    <= '0;
            r_j    <= IW'(1);
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_bad  <= 1'b0;
            r_seen <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_seen[w_dist] <= 1'b1;
            if (w_cur_bad) r_bad <= 1'b1;
            r_cnt <= r_cnt + CW'(1);
            if (o_last) begin
                r_busy <= 1'b0;
            end else if (r_j == IW'(NUMPOSITIONS)) begin
                r_i <= r_i + IW'(1);
                r_j <= r_i + IW'(2);
            end else begin
                r_j <= r_j + IW'(1);
            end
        end
    end

endmodule

// File: rtl/golomb_solution_recorder.sv
// Records the shortest ruler reported by the mark counters and publishes the
// current length bound. Optional pair self-check: GOLOMB_SELFCHECK_EN.
module golomb_solution_recorder
    import golomb_pkg::*;
#(
    parameter int unsigned NUMPOSITIONS = 5,
    parameter int unsigned POSW         = 8,
    parameter int unsigned INIT_LIMIT   = 255
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             sol_valid,
    input  logic [(NUMPOSITIONS+1)*POSW-1:0] marks_in,
    input  logic                             search_done,
    output logic                             sol_ready,
    output logic [POSW-1:0]                  limit,
    output logic [(NUMPOSITIONS+1)*POSW-1:0] best_marks,
    output logic                             best_valid,
    output logic [15:0]                      sol_count,
    output logic [7:0]                       reject_count,
    output logic                             finished
);

    localparam int unsigned MW = (NUMPOSITIONS + 1) * POSW;

    state_t          r_state;
    state_t          w_next;
    logic [MW-1:0]   r_marks;
    logic [MW-1:0]   r_best;
    logic [POSW-1:0] r_limit;
    logic            r_best_valid;
    logic [15:0]     r_sol_cnt;
    logic [7:0]      r_rej_cnt;
    logic            r_armed;
    logic            r_done_req;
    logic [POSW-1:0] w_len;
    logic            w_len_ok;
    logic            w_accept;
    logic            w_pair_done;
    logic            w_pair_ok;
    logic            w_reject;
    logic            w_done_req;

    assign w_len      = r_marks[POSW-1:0];
    assign w_len_ok   = (w_len < r_limit);
    assign w_accept   = sol_ready && sol_valid;
    assign w_done_req = search_done || r_done_req;

`ifdef GOLOMB_SELFCHECK_EN
    logic w_chk_start;
    logic w_chk_abort;
    logic w_chk_busy;
    logic w_chk_last;

    assign w_chk_start = w_accept;
    assign w_chk_abort = (r_state == ST_CHECK) && !w_len_ok;
    assign w_pair_done = w_chk_busy && w_chk_last;

    golomb_pair_checker #(
        .NUMPOSITIONS (NUMPOSITIONS),
        .POSW         (POSW)
    ) u_pair_checker (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_chk_start),
        .i_abort (w_chk_abort),
        .i_marks (r_marks),
        .o_busy  (w_chk_busy),
        .o_last  (w_chk_last),
        .o_ok    (w_pair_ok)
    );
`else
    assign w_pair_done = 1'b1;
    assign w_pair_ok   = 1'b1;
`endif

    assign w_reject = (r_state == ST_CHECK) && (!w_len_ok || (w_pair_done && !w_pair_ok));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // A done request seen mid-ruler lets that ruler finish, then goes straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)         w_next = ST_CHECK;
                else if (search_done) w_next = ST_DONE;
            end
            ST_CHECK: begin
                if (w_reject)         w_next = w_done_req ? ST_DONE : ST_IDLE;
                else if (w_pair_done) w_next = ST_STORE;
            end
            ST_STORE: w_next = w_done_req ? ST_DONE : ST_IDLE;
            ST_DONE:  w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sol_ready = (r_state == ST_IDLE) && r_armed;
        finished  = (r_state == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_marks      <= '0;
            r_best       <= '0;
            r_limit      <= POSW'(INIT_LIMIT);
            r_best_valid <= 1'b0;
            r_sol_cnt    <= '0;
            r_rej_cnt    <= '0;
            r_armed      <= 1'b0;
            r_done_req   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) r_marks <= marks_in;
            if (((r_state == ST_CHECK) || (r_state == ST_STORE)) && search_done)
                r_done_req <= 1'b1;
            if (w_reject) r_rej_cnt <= 8'(sat_inc(16'(r_rej_cnt), 8));
            if (r_state == ST_STORE) begin
                r_best       <= r_marks;
                r_best_valid <= 1'b1;
                r_limit      <= w_len;
                r_sol_cnt    <= sat_inc(r_sol_cnt, 16);
            end
        end
    end

    assign limit        = r_limit;
    assign best_marks   = r_best;
    assign best_valid   = r_best_valid;
    assign sol_count    = r_sol_cnt;
    assign reject_count = r_rej_cnt;

endmodule

// File: doc/golomb_solution_recorder.md
GOLOMB_SOLUTION_RECORDER -- requirements
Module: golomb_solution_recorder

Interface
- REQ-001 SHALL have parameter NUMPOSITIONS, default 5: index of the last mark; marks m[0..NUMPOSITIONS], m[0]==0.
- REQ-002 SHALL have parameter POSW, default 8: bit width of one position value.
- REQ-003 SHALL have parameter INIT_LIMIT, default 255: limit value after reset.
- REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic is on its rising edge.
- REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port sol_valid, input, 1 bit: the last mark counter reports a complete distance-clean ruler.
- REQ-007 SHALL have port marks_in, input, (NUMPOSITIONS+1)*POSW bits: packed {m[0],...,m[NUMPOSITIONS]}, with m[0] in the MSBs.
- REQ-008 SHALL have port search_done, input, 1 bit: the head level reports exhausted search; sampled as a level.
- REQ-009 SHALL have port sol_ready, output, 1 bit: recorder can accept a ruler.
- REQ-010 SHALL have port limit, output, POSW bits: current bound fed to all mark counters.
- REQ-011 SHALL have port best_marks, output, same width as marks_in: best ruler stored so far.
- REQ-012 SHALL have port best_valid, output, 1 bit: best_marks holds a ruler.
- REQ-013 SHALL have port sol_count, output, 16 bits: number of accepted rulers, saturating.
- REQ-014 SHALL have port reject_count, output, 8 bits: number of rulers discarded as stale or invalid, saturating.
- REQ-015 SHALL have port finished, output, 1 bit: search is over and the result is final.

Function
- REQ-016 SHALL implement the FSM states IDLE, CHECK, STORE and DONE.
- REQ-017 SHALL drive sol_ready=1 only in IDLE; a ruler is accepted in a cycle where sol_valid and sol_ready are both 1, and marks_in is latched in that cycle.
- REQ-018 SHALL, on acceptance, compute L=m[NUMPOSITIONS] and go IDLE->CHECK on the next edge.
- REQ-019 SHALL, in CHECK, discard the ruler if L>=limit: reject_count+1, back to IDLE, no other change; this covers a limit that dropped while the ruler was in flight, and equal lengths.
- REQ-020 SHALL, in CHECK, otherwise go to STORE; in STORE it loads best_marks, sets best_valid=1, sets limit=L, sets sol_count+1, and returns to IDLE.
- REQ-021 SHALL, without the self-check, update limit 3 cycles after the accept edge and raise sol_ready again in the cycle after STORE.
- REQ-022 SHALL leave IDLE for DONE if search_done=1 while in IDLE; if search_done rises in CHECK or STORE, the current ruler completes first and the FSM then enters DONE.
- REQ-023 SHALL make DONE absorbing until reset: finished=1, sol_ready=0, all other outputs frozen.
- REQ-024 SHALL, if sol_valid and search_done are both 1 in IDLE, accept the ruler first; DONE is entered afterwards.
- REQ-025 SHALL use width-exact arithmetic: the counters saturate at all-ones, and the comparison L<limit is unsigned and POSW bits wide.
- REQ-026 SHALL ignore sol_valid outside IDLE; the upstream stage holds its data until sol_ready.

Reset
- REQ-027 SHALL, while reset=0, asynchronously force: state=IDLE, limit=INIT_LIMIT, best_marks=0, best_valid=0, sol_count=0, reject_count=0, finished=0, sol_ready=0.
- REQ-028 SHALL raise sol_ready on the first rising clock edge after reset deasserts.
- REQ-029 SHALL abandon an in-flight ruler on reset mid-operation, with no partial store.

Configuration
- REQ-030 SHALL, with GOLOMB_SELFCHECK_EN defined, add a self-check in CHECK (after the length test passes): one pair (i<j) is visited per cycle, the distance m[j]-m[i] is set in a 2^POSW-bit seen-vector, and a repeat or non-increasing pair sets reject_count+1 and returns to IDLE; CHECK lasts P=(NUMPOSITIONS+1)*NUMPOSITIONS/2 cycles (15 at default).
- REQ-031 SHALL, without GOLOMB_SELFCHECK_EN, have no seen-vector and a CHECK state of exactly 1 cycle.

Structure
- REQ-032 SHALL place the state encoding, the P constant function and the saturating-increment helper in the shared package golomb_pkg, which mark counters also use.
- REQ-033 SHALL put the self-check in sub-module golomb_pair_checker (start/busy/ok handshake, iterates pairs), instantiated only under GOLOMB_SELFCHECK_EN.

Verification
- REQ-034 SHALL bench: reset, then marks {0,1,3,7,12,20} -> limit=20 at accept+3, best_valid=1, sol_count=1.
- REQ-035 SHALL bench: next, {0,1,4,10,12,17} -> limit=17, best_marks updated; then {0,1,8,11,13,17} -> rejected (equal length), reject_count=1, limit stays 17.
- REQ-036 SHALL bench: sol_valid held high through CHECK/STORE -> exactly one acceptance per ruler, sol_ready low in those cycles.
- REQ-037 SHALL bench: with GOLOMB_SELFCHECK_EN, {0,1,2,4,8,16} (distance 1 repeated) -> rejected, limit unchanged; a valid 17 ruler gives limit=17 at accept+17.
- REQ-038 SHALL bench: search_done asserted during STORE -> the store completes, then finished=1 and sol_ready=0 are permanent.
- REQ-039 SHALL bench: reset pulled low during CHECK -> limit=INIT_LIMIT, best_valid=0 immediately, with no clock edge needed.
